// File: rtl/pix_scan_pkg.sv
// pix_scan_pkg: shared state type, default widths and lane-id width helper
// for the pixel-scan generator.
package pix_scan_pkg;

  localparam int DEF_X_BITS = 10;
  localparam int DEF_Y_BITS = 10;
  localparam int DEF_LANES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Lane-id width is clog2 of the lane count, but never narrower than one bit.
  function automatic int lane_bits(input int lanes);
    if (lanes <= 2) return 1;
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/pix_scan_if.sv
// pix_scan_if: control and coordinate-stream signals of the pixel-scan
// generator. The slave modport is the generator's view; the master modport
// is the frame controller / lane dispatcher side.
interface pix_scan_if
  import pix_scan_pkg::*;
#(
  parameter int X_BITS = DEF_X_BITS,
  parameter int Y_BITS = DEF_Y_BITS,
  parameter int LANES  = DEF_LANES
);

  localparam int LANE_BITS = lane_bits(LANES);

  logic                 clear;
  logic                 start;
  logic [X_BITS-1:0]    x_max;
  logic [Y_BITS-1:0]    y_max;
  logic                 serp;
  logic                 pix_ready;
  logic                 pix_valid;
  logic [X_BITS-1:0]    x_value;
  logic [Y_BITS-1:0]    y_value;
  logic [LANE_BITS-1:0] lane_id;
  logic                 pix_last;
  logic                 busy;
  logic                 done;

  modport slave (
    input  clear, start, x_max, y_max, serp, pix_ready,
    output pix_valid, x_value, y_value, lane_id, pix_last, busy, done
  );

  modport master (
    output clear, start, x_max, y_max, serp, pix_ready,
    input  pix_valid, x_value, y_value, lane_id, pix_last, busy, done
  );

endinterface

// File: rtl/pix_scan_axis_cnt.sv
// scan_axis_cnt: one scan axis counter with synchronous clear, enable and an
// inclusive maximum. at_end flags the last position in the current count
// direction. The down-count direction exists only when
// PIX_SCAN_SERPENTINE_EN is defined; otherwise the down input is ignored.
module scan_axis_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         en,
  input  logic         down,
  input  logic [W-1:0] max,
  output logic [W-1:0] value,
  output logic         at_end
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

`ifdef PIX_SCAN_SERPENTINE_EN
  assign at_end = down ? (value_q == '0) : (value_q == max);
`else
  logic unused_down;
  assign unused_down = down;
  assign at_end      = (value_q == max);
`endif

  // Next count value: equality-based wrap so an all-ones max never overflows.
  always_comb begin
    value_d = (value_q == max) ? '0 : value_q + 1'b1;
`ifdef PIX_SCAN_SERPENTINE_EN
    if (down) value_d = (value_q == '0) ? max : value_q - 1'b1;
`endif
  end

  // Counter register: clear beats enable, enable steps toward the end.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     value_q <= '0;
    else if (clear) value_q <= '0;
    else if (en)    value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/pix_scan.sv
// pix_scan: walks an inclusive (x_max+1) x (y_max+1) frame, issuing one
// coordinate per valid/ready beat with a round-robin lane tag, flagging the
// final pixel and pulsing done when the frame completes.
// Optional feature macro: PIX_SCAN_SERPENTINE_EN (serpentine row order).
module pix_scan
  import pix_scan_pkg::*;
#(
  parameter int X_BITS = DEF_X_BITS,
  parameter int Y_BITS = DEF_Y_BITS,
  parameter int LANES  = DEF_LANES
) (
  input logic       clk,
  input logic       n_rst,
  pix_scan_if.slave bus
);

  localparam int LANE_BITS = lane_bits(LANES);

  state_t               state_q;
  state_t               state_d;
  logic [X_BITS-1:0]    x_max_q;
  logic [Y_BITS-1:0]    y_max_q;
  logic [LANE_BITS-1:0] lane_q;
  logic [X_BITS-1:0]    x_val;
  logic [Y_BITS-1:0]    y_val;
  logic                 x_at_end;
  logic                 unused_y_end;
  logic                 start_ok;
  logic                 accept;
  logic                 final_beat;
  logic                 step;
  logic                 cnt_clear;
  logic                 x_down;
  logic                 serp_turn;

  assign start_ok   = (state_q == IDLE) && bus.start && !bus.clear;
  assign accept     = (state_q == RUN) && bus.pix_ready;
  assign final_beat = x_at_end && (y_val == y_max_q);
  assign step       = accept && !final_beat && !bus.clear;
  assign cnt_clear  = bus.clear || start_ok;

`ifdef PIX_SCAN_SERPENTINE_EN
  logic serp_q;

  // Serpentine request is captured with the frame size on an accepted start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        serp_q <= 1'b0;
    else if (start_ok) serp_q <= bus.serp;
  end

  assign x_down    = serp_q && y_val[0];
  assign serp_turn = serp_q && x_at_end;
`else
  logic unused_serp;
  assign unused_serp = bus.serp;
  assign x_down      = 1'b0;
  assign serp_turn   = 1'b0;
`endif

  // Frame size is captured on an accepted start and held for the whole frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_max_q <= '0;
      y_max_q <= '0;
    end else if (start_ok) begin
      x_max_q <= bus.x_max;
      y_max_q <= bus.y_max;
    end
  end

  // Round-robin lane tag; holds on the final beat along with the coordinates.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)         lane_q <= '0;
    else if (cnt_clear) lane_q <= '0;
    else if (step)      lane_q <= (lane_q == LANE_BITS'(LANES - 1)) ? '0 : lane_q + 1'b1;
  end

  scan_axis_cnt #(.W(X_BITS)) u_x_cnt (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (cnt_clear),
    .en     (step && !serp_turn),
    .down   (x_down),
    .max    (x_max_q),
    .value  (x_val),
    .at_end (x_at_end)
  );

  scan_axis_cnt #(.W(Y_BITS)) u_y_cnt (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (cnt_clear),
    .en     (step && x_at_end),
    .down   (1'b0),
    .max    (y_max_q),
    .value  (y_val),
    .at_end (unused_y_end)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start)             state_d = RUN;
      RUN:     if (accept && final_beat)  state_d = DONE;
      DONE:                               state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
    if (bus.clear) state_d = IDLE;
  end

  // Outputs decoded from state and the live counters.
  always_comb begin
    bus.pix_valid = (state_q == RUN);
    bus.pix_last  = (state_q == RUN) && final_beat;
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
  end

  assign bus.x_value = x_val;
  assign bus.y_value = y_val;
  assign bus.lane_id = lane_q;

endmodule

// File: tb/tb_pix_scan.sv
// tb_pix_scan: directed stimulus with a beat scoreboard. Stimulus pushes the
// expected beats; a negedge monitor pops and compares every accepted beat.
module tb_pix_scan;
  import pix_scan_pkg::*;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int LN = 4;
  localparam int LB = lane_bits(LN);

  typedef struct packed {
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic [LB-1:0] lane;
    logic          last;
  } beat_t;

  logic  clk = 1'b0;
  logic  n_rst;
  beat_t exp_q[$];
  beat_t mon_exp;
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  pix_scan_if #(.X_BITS(XB), .Y_BITS(YB), .LANES(LN)) pif ();

  pix_scan #(.X_BITS(XB), .Y_BITS(YB), .LANES(LN)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (pif.slave)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_beat(input int x, input int y, input int lane, input bit last);
    beat_t b;
    b.x    = XB'(x);
    b.y    = YB'(y);
    b.lane = LB'(lane);
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Raster order for a frame, truncated to n beats (n < 0 means whole frame).
  task automatic push_raster(input int xm, input int ym, input int n);
    int idx = 0;
    for (int y = 0; y <= ym; y++)
      for (int x = 0; x <= xm; x++) begin
        if (n < 0 || idx < n) push_beat(x, y, idx % LN, (x == xm) && (y == ym));
        idx++;
      end
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && pif.pix_valid === 1'b1 && pif.pix_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got (%0d,%0d) expected no beat", pif.x_value, pif.y_value);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("beat_x",    32'(pif.x_value), 32'(mon_exp.x));
        check_output("beat_y",    32'(pif.y_value), 32'(mon_exp.y));
        check_output("beat_lane", 32'(pif.lane_id), 32'(mon_exp.lane));
        check_output("beat_last", 32'(pif.pix_last), 32'(mon_exp.last));
      end
    end
  end

  task automatic apply_stimulus(input int xm, input int ym, input bit s);
    @(posedge clk); #1;
    pif.x_max = XB'(xm);
    pif.y_max = YB'(ym);
    pif.serp  = s;
    pif.start = 1'b1;
    @(posedge clk); #1;
    pif.start = 1'b0;
    check_output("valid_after_start", 32'(pif.pix_valid), 32'd1);
  endtask

  task automatic wait_for(input int xv, input int yv);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (pif.pix_valid === 1'b1 && pif.x_value == XB'(xv) && pif.y_value == YB'(yv)) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_coord: got timeout expected (%0d,%0d)", xv, yv);
    end
  endtask

  task automatic finish_frame(input string name);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (pif.pix_valid === 1'b1 && pif.pix_ready === 1'b1 && pif.pix_last === 1'b1) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_last: got timeout expected final beat", name);
    end else begin
      @(negedge clk);
      check_output({name, "_done"},       32'(pif.done), 32'd1);
      check_output({name, "_done_busy"},  32'(pif.busy), 32'd1);
      check_output({name, "_done_valid"}, 32'(pif.pix_valid), 32'd0);
      @(negedge clk);
      check_output({name, "_idle_done"},  32'(pif.done), 32'd0);
      check_output({name, "_idle_busy"},  32'(pif.busy), 32'd0);
    end
  endtask

  task automatic check_quiet(input string name);
    check_output({name, "_valid"}, 32'(pif.pix_valid), 32'd0);
    check_output({name, "_x"},     32'(pif.x_value), 32'd0);
    check_output({name, "_y"},     32'(pif.y_value), 32'd0);
    check_output({name, "_lane"},  32'(pif.lane_id), 32'd0);
    check_output({name, "_last"},  32'(pif.pix_last), 32'd0);
    check_output({name, "_busy"},  32'(pif.busy), 32'd0);
    check_output({name, "_done"},  32'(pif.done), 32'd0);
  endtask

  initial begin
    n_rst         = 1'b1;
    pif.clear     = 1'b0;
    pif.start     = 1'b0;
    pif.x_max     = '0;
    pif.y_max     = '0;
    pif.serp      = 1'b0;
    pif.pix_ready = 1'b1;
    #2 n_rst = 1'b0;
    #10 check_quiet("reset");
    #11 n_rst = 1'b1;

    // Raster frame 4x3
    push_raster(3, 2, -1);
    apply_stimulus(3, 2, 0);
    finish_frame("raster");

    // Backpressure at (2,1)
    push_raster(3, 2, -1);
    apply_stimulus(3, 2, 0);
    wait_for(1, 1);
    @(posedge clk); #1;
    pif.pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("stall_x",     32'(pif.x_value), 32'd2);
      check_output("stall_y",     32'(pif.y_value), 32'd1);
      check_output("stall_lane",  32'(pif.lane_id), 32'd2);
      check_output("stall_valid", 32'(pif.pix_valid), 32'd1);
      check_output("stall_last",  32'(pif.pix_last), 32'd0);
      @(posedge clk);
    end
    #1 pif.pix_ready = 1'b1;
    finish_frame("stall");

    // Lane tags over a 6x1 frame, then a 1x1 frame
    push_beat(0, 0, 0, 0); push_beat(1, 0, 1, 0); push_beat(2, 0, 2, 0);
    push_beat(3, 0, 3, 0); push_beat(4, 0, 0, 0); push_beat(5, 0, 1, 1);
    apply_stimulus(5, 0, 0);
    finish_frame("lanes");
    push_beat(0, 0, 0, 1);
    apply_stimulus(0, 0, 0);
    finish_frame("one");

    // Serpentine request on a 3x2 frame
`ifdef PIX_SCAN_SERPENTINE_EN
    push_beat(0, 0, 0, 0); push_beat(1, 0, 1, 0); push_beat(2, 0, 2, 0);
    push_beat(2, 1, 3, 0); push_beat(1, 1, 0, 0); push_beat(0, 1, 1, 1);
`else
    push_beat(0, 0, 0, 0); push_beat(1, 0, 1, 0); push_beat(2, 0, 2, 0);
    push_beat(0, 1, 3, 0); push_beat(1, 1, 0, 0); push_beat(2, 1, 1, 1);
`endif
    apply_stimulus(2, 1, 1);
    finish_frame("serp");
    pif.serp = 1'b0;

    // Clear together with an accepted beat at beat 5, then a full restart
    push_raster(3, 2, 5);
    apply_stimulus(3, 2, 0);
    wait_for(3, 0);
    @(posedge clk); #1;
    pif.clear = 1'b1;
    @(posedge clk); #1;
    pif.clear = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    @(negedge clk);
    check_output("abort_no_done", 32'(pif.done), 32'd0);
    push_raster(3, 2, -1);
    apply_stimulus(3, 2, 0);
    finish_frame("restart");

    // Start during RUN with a different size is ignored
    push_raster(3, 2, -1);
    apply_stimulus(3, 2, 0);
    wait_for(2, 0);
    @(posedge clk); #1;
    pif.x_max = XB'(1);
    pif.y_max = YB'(0);
    pif.start = 1'b1;
    @(posedge clk); #1;
    pif.start = 1'b0;
    finish_frame("ignored_start");

    // Asynchronous reset at beat 4
    push_raster(3, 2, 4);
    apply_stimulus(3, 2, 0);
    wait_for(3, 0);
    #2 n_rst = 1'b0;
    #1 check_quiet("async_rst");
    @(posedge clk); #3;
    n_rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_quiet("post_rst");
    end
    push_beat(0, 0, 0, 0); push_beat(1, 0, 1, 1);
    apply_stimulus(1, 0, 0);
    finish_frame("after_rst");

    repeat (2) @(negedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
